figaro_collector: RTL and testbench

Entropy collector for the TRNG, directly upstream of the `figaro` bus wrapper. It synchronises the raw ring-oscillator noise bit and samples it at a programmable rate. Samples are shifted into 32-bit words, and each completed word is presented to the wrapper with a ready flag until the wrapper consumes it. An optional repetition-count health test blocks output when the noise source appears stuck.

---
 rtl/figaro_collector.sv | 168 ++++++++++++++++
 tb/tb_figaro_collector.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/figaro_collector.sv
// figaro_collector: TRNG entropy collector feeding the figaro bus wrapper.
// It synchronises the raw ring-oscillator bit and samples it every rate_q
// clocks. Samples are packed into 32-bit words, and each word is held with
// `ready` until it is consumed.
// Optional feature macro: FIGARO_HEALTH_EN. It adds a repetition-count
// health test that latches a sticky failure when the source looks stuck.
module figaro_collector #(
  parameter int unsigned RCT_CUTOFF   = 40,
  parameter logic [23:0] DEFAULT_RATE = 24'h001000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        noise,
  input  logic        read_entropy,
  input  logic        set_sample_rate,
  input  logic [23:0] sample_rate,
  output logic [31:0] entropy,
  output logic        ready,
  output logic        health_fail
);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_FAIL    = 2'd2
  } state_e;

  logic        noise_meta_q;
  logic        noise_s_q;
  logic [23:0] rate_q;
  logic [23:0] rate_d;
  logic [23:0] rate_ctr_q;
  logic [5:0]  bit_ctr_q;
  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [31:0] entropy_q;
  logic        ready_q;
  state_e      state_q;
  logic        sample_evt;
  logic        word_done;
  logic        rct_trip;

  // A requested period of zero would never wrap, so it runs at full rate.
  assign rate_d     = (sample_rate == 24'd0) ? 24'd1 : sample_rate;
  assign sample_evt = (state_q == ST_COLLECT) && (rate_ctr_q == rate_q - 24'd1);
  assign shift_d    = {shift_q[30:0], noise_s_q};
  assign word_done  = (bit_ctr_q == 6'd31);

  // Two-flop synchroniser for the asynchronous oscillator bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      noise_meta_q <= 1'b0;
      noise_s_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop capture its pre-edge
      // input; blocking ones would collapse the two stages into one.
      noise_meta_q <= noise;
      noise_s_q    <= noise_meta_q;
    end
  end

`ifdef FIGARO_HEALTH_EN
  logic [7:0] run_q;
  logic [7:0] run_d;
  logic       prev_q;
  logic       health_q;

  // Next run length: restart on the first sample or on a change, and saturate.
  always_comb begin
    // NOTE: default first, so every path assigns run_d and no latch is built.
    run_d = run_q;
    if (run_q == 8'd0 || noise_s_q != prev_q) begin
      run_d = 8'd1;
    end else if (run_q != 8'hFF) begin
      run_d = run_q + 8'd1;
    end
  end

  assign rct_trip = sample_evt && (run_d >= 8'(RCT_CUTOFF));

  // Repetition-count state. It only advances on sample events in COLLECT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q    <= 8'd0;
      prev_q   <= 1'b0;
      health_q <= 1'b0;
    end else if (set_sample_rate) begin
      run_q    <= 8'd0;
      prev_q   <= 1'b0;
      health_q <= 1'b0;
    end else if (sample_evt) begin
      run_q  <= run_d;
      prev_q <= noise_s_q;
      if (rct_trip) begin
        health_q <= 1'b1;
      end
    end
  end

  assign health_fail = health_q;
`else
  assign rct_trip    = 1'b0;
  assign health_fail = 1'b0;
`endif

  // Collection FSM with rate counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rate_q     <= DEFAULT_RATE;
      rate_ctr_q <= 24'd0;
      bit_ctr_q  <= 6'd0;
      shift_q    <= 32'd0;
      entropy_q  <= 32'd0;
      ready_q    <= 1'b0;
      state_q    <= ST_COLLECT;
    end else if (set_sample_rate) begin
      // A rate change restarts the partial word. A held word survives
      // unless it is read in the same cycle.
      rate_q     <= rate_d;
      rate_ctr_q <= 24'd0;
      bit_ctr_q  <= 6'd0;
      shift_q    <= 32'd0;
      if (state_q == ST_FAIL) begin
        state_q <= ST_COLLECT;
      end else if (state_q == ST_FULL && read_entropy) begin
        ready_q <= 1'b0;
        state_q <= ST_COLLECT;
      end
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          rate_ctr_q <= sample_evt ? 24'd0 : rate_ctr_q + 24'd1;
          if (sample_evt) begin
            shift_q <= shift_d;
            if (rct_trip) begin
              bit_ctr_q <= 6'd0;
              state_q   <= ST_FAIL;
            end else if (word_done) begin
              entropy_q <= shift_d;
              ready_q   <= 1'b1;
              bit_ctr_q <= 6'd0;
              state_q   <= ST_FULL;
            end else begin
              bit_ctr_q <= bit_ctr_q + 6'd1;
            end
          end
        end
        ST_FULL: begin
          rate_ctr_q <= 24'd0;
          if (read_entropy) begin
            ready_q <= 1'b0;
            state_q <= ST_COLLECT;
          end
        end
        ST_FAIL: begin
          rate_ctr_q <= 24'd0;
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign entropy = entropy_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_figaro_collector.sv
// Directed self-checking bench for figaro_collector.
// The repetition-count section follows FIGARO_HEALTH_EN, as the RTL does.
module tb_figaro_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        noise;
  logic        read_entropy;
  logic        set_sample_rate;
  logic [23:0] sample_rate;
  logic [31:0] entropy;
  logic        ready;
  logic        health_fail;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int tog_base  = 0;
  int tog_period = 1;
  bit tog_en    = 1'b0;
  bit stable;
  logic [31:0] last_word;

  always #5 clk = ~clk;

  figaro_collector #(
    .RCT_CUTOFF  (40),
    .DEFAULT_RATE(24'h001000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .noise          (noise),
    .read_entropy   (read_entropy),
    .set_sample_rate(set_sample_rate),
    .sample_rate    (sample_rate),
    .entropy        (entropy),
    .ready          (ready),
    .health_fail    (health_fail)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tog_en && ((cyc - tog_base) % tog_period == 0)) noise = ~noise;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [23:0] r);
    sample_rate     = r;
    set_sample_rate = 1'b1;
    step();
    set_sample_rate = 1'b0;
  endtask

  task automatic pulse_read();
    read_entropy = 1'b1;
    step();
    read_entropy = 1'b0;
  endtask

  // Noise holds `first` for `period` edges and then alternates. With the
  // sample period equal to `period`, the k-th sample after this point sees
  // first, ~first, first, ...
  task automatic start_toggle(input int period, input logic first);
    tog_en     = 1'b1;
    tog_base   = cyc;
    tog_period = period;
    noise      = first;
  endtask

  initial begin
    reset_n         = 1'b0;
    noise           = 1'b0;
    read_entropy    = 1'b0;
    set_sample_rate = 1'b0;
    sample_rate     = 24'd0;

    // Reset state
    steps(3);
    check("rst_entropy", entropy, 32'h0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_health", {31'd0, health_fail}, 32'd0);
    reset_n = 1'b1;
    steps(5);
    check("post_rst_ready", {31'd0, ready}, 32'd0);

    // Word 1 at rate 4, alternating noise starting with 1
    load(24'd4);
    start_toggle(4, 1'b1);
    steps(127);
    check("w1_not_early", {31'd0, ready}, 32'd0);
    check("w1_entropy_pre", entropy, 32'h0);
    step();
    check("w1_ready_at_128", {31'd0, ready}, 32'd1);
    check("w1_entropy", entropy, 32'hAAAAAAAA);
    check("w1_health", {31'd0, health_fail}, 32'd0);

    // Hold in FULL for 200 cycles without a read
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (ready !== 1'b1 || entropy !== 32'hAAAAAAAA) stable = 1'b0;
    end
    check("full_hold_stable", {31'd0, stable}, 32'd1);

    // Read, then the next word starts with a 0 bit
    pulse_read();
    start_toggle(4, 1'b0);
    check("read_clears_ready", {31'd0, ready}, 32'd0);
    check("entropy_kept_on_read", entropy, 32'hAAAAAAAA);
    steps(49);
    pulse_read();               // ignored outside FULL
    steps(77);
    check("w2_not_early", {31'd0, ready}, 32'd0);
    step();
    check("w2_ready_at_128", {31'd0, ready}, 32'd1);
    check("w2_entropy", entropy, 32'h55555555);

    // Simultaneous read + rate load of 0 (runs as 1), constant noise 1
    tog_en = 1'b0;
    noise  = 1'b1;
    step();
    sample_rate     = 24'd0;
    set_sample_rate = 1'b1;
    read_entropy    = 1'b1;
    step();
    set_sample_rate = 1'b0;
    read_entropy    = 1'b0;
    check("sim_read_set_ready", {31'd0, ready}, 32'd0);
    steps(31);
    check("rate0_not_early", {31'd0, ready}, 32'd0);
    step();
    check("rate0_ready_at_32", {31'd0, ready}, 32'd1);
    check("rate0_entropy", entropy, 32'hFFFFFFFF);

    // Change the rate to 8 after 17 bits at rate 4
    pulse_read();
    load(24'd4);
    start_toggle(4, 1'b1);
    steps(70);
    check("partial_17_bits", {31'd0, ready}, 32'd0);
    load(24'd8);
    start_toggle(8, 1'b1);
    steps(255);
    check("rate8_not_early", {31'd0, ready}, 32'd0);
    step();
    check("rate8_ready_at_256", {31'd0, ready}, 32'd1);
    check("rate8_entropy", entropy, 32'hAAAAAAAA);

    // Stuck-at-1 source at rate 1
    pulse_read();
    tog_en = 1'b0;
    noise  = 1'b1;
    step();
    load(24'd1);
    steps(32);
    check("stuck_w1_ready", {31'd0, ready}, 32'd1);
    check("stuck_w1_entropy", entropy, 32'hFFFFFFFF);
    check("stuck_w1_health", {31'd0, health_fail}, 32'd0);
    pulse_read();
`ifdef FIGARO_HEALTH_EN
    // Run of identical samples reaches 40 on the 8th sample after the read
    steps(7);
    check("rct_39_no_fail", {31'd0, health_fail}, 32'd0);
    step();
    check("rct_40_fail", {31'd0, health_fail}, 32'd1);
    check("rct_fail_ready", {31'd0, ready}, 32'd0);
    steps(50);
    check("rct_fail_sticky", {31'd0, health_fail}, 32'd1);
    check("rct_fail_no_ready", {31'd0, ready}, 32'd0);
    load(24'd4);
    start_toggle(4, 1'b1);
    check("set_clears_fail", {31'd0, health_fail}, 32'd0);
    steps(128);
    check("post_fail_ready", {31'd0, ready}, 32'd1);
    check("post_fail_entropy", entropy, 32'hAAAAAAAA);
    check("post_fail_health", {31'd0, health_fail}, 32'd0);
    last_word = 32'hAAAAAAAA;
`else
    // Without the health test a stuck source still yields words
    steps(31);
    check("stuck_w2_not_early", {31'd0, ready}, 32'd0);
    step();
    check("stuck_w2_ready", {31'd0, ready}, 32'd1);
    check("stuck_w2_health", {31'd0, health_fail}, 32'd0);
    last_word = 32'hFFFFFFFF;
`endif

    // Asynchronous reset while collecting
    pulse_read();
    steps(20);
    check("mid_collect_ready", {31'd0, ready}, 32'd0);
    check("mid_collect_entropy", entropy, last_word);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_entropy", entropy, 32'h0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_health", {31'd0, health_fail}, 32'd0);
    steps(2);
    reset_n = 1'b1;
    steps(40);
    check("after_rst_default_rate", {31'd0, ready}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
